memory_cycle_lsu: RTL and testbench

- Parametrised successor to the MEM stage of the 5-stage RV32I pipeline; sits between the EX/M register and the W stage.
- Adds the following over the plain word-only stage:
  - full load/store width support (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte enables and sign/zero extension;
  - misalignment detection;
  - configurable data-memory latency with a stall handshake to the hazard unit.
- Contains the data memory array and the M/W pipeline register.

---
 rtl/riscv_mem_pkg.sv | 19 +
 rtl/lsu_align.sv | 53 +++++
 rtl/memory_cycle_lsu.sv | 134 +++++++++++++
 tb/tb_memory_cycle_lsu.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the RV32I memory stage: access sizes, writeback selects, FSM states.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } mem_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for loads/stores: byte enables, replicated store data,
// load extraction with sign/zero extension, and misalignment detection.
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] store_data,
  input  logic [31:0] word_in,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word_in[{addr_lo, 3'b000} +: 8];
    sel_half = word_in[{addr_lo[1], 4'b0000} +: 16];

    misalign = (mem_read | mem_write) &
               ((((funct3 == F3_H) | (funct3 == F3_HU)) & addr_lo[0]) |
                ((funct3 == F3_W) & (addr_lo != 2'b00)));

    byte_en    = '0;
    store_word = store_data;
    case (funct3)
      F3_B: begin
        byte_en    = 4'b0001 << addr_lo;
        store_word = {4{store_data[7:0]}};
      end
      F3_H: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_word = {2{store_data[15:0]}};
      end
      F3_W:    byte_en = '1;
      default: byte_en = '0;
    endcase

    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_BU:   load_data = {24'h0, sel_byte};
      F3_HU:   load_data = {16'h0, sel_half};
      default: load_data = word_in;
    endcase
  end

endmodule

// File: rtl/memory_cycle_lsu.sv
// MEM stage with byte/half/word access, configurable memory latency and the M/W
// pipeline register; stalls the hazard unit while an access is waiting.
module memory_cycle_lsu
  import riscv_mem_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DMEM_DEPTH  = 1024,
  parameter int unsigned MEM_LATENCY = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteM,
  input  logic            MemWriteM,
  input  logic            MemReadM,
  input  logic [1:0]      ResultSrcM,
  input  logic [2:0]      Funct3M,
  input  logic [4:0]      RD_M,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] ALU_ResultM,
  output logic            StallM,
  output logic            MisalignM,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic [4:0]      RD_W,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [XLEN-1:0] ALU_ResultW,
  output logic [XLEN-1:0] ReadDataW
);

  localparam int unsigned AW = $clog2(DMEM_DEPTH);

  logic [XLEN-1:0] dmem [DMEM_DEPTH];

  mem_state_e      state, state_next;
  logic [2:0]      cnt, cnt_next;
  logic            access, stall, complete, misalign;
  logic [AW-1:0]   idx;
  logic [3:0]      byte_en;
  logic [XLEN-1:0] store_word, load_data, word_rd;
  logic            unused_addr;

  assign access      = MemReadM | MemWriteM;
  assign idx         = ALU_ResultM[AW+1:2];
  assign unused_addr = ^ALU_ResultM[XLEN-1:AW+2];
  assign word_rd     = dmem[idx];

  lsu_align u_align (
    .funct3     (Funct3M),
    .addr_lo    (ALU_ResultM[1:0]),
    .mem_read   (MemReadM),
    .mem_write  (MemWriteM),
    .store_data (WriteDataM),
    .word_in    (word_rd),
    .byte_en    (byte_en),
    .store_word (store_word),
    .load_data  (load_data),
    .misalign   (misalign)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall      = 1'b0;
    complete   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (access && !misalign) begin
          if (MEM_LATENCY == 0) begin
            complete = 1'b1;
          end else begin
            stall      = 1'b1;
            state_next = ST_WAIT;
            cnt_next   = 3'(MEM_LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt != 3'd0) begin
          stall    = 1'b1;
          cnt_next = cnt - 3'd1;
        end else begin
          complete   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Held inactive in reset so the hazard unit is not frozen by a stale request.
  assign StallM    = stall & rst;
  assign MisalignM = misalign;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (complete && MemWriteM) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) dmem[idx][8*b +: 8] <= store_word[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= '0;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
    end else if (stall) begin
      RegWriteW <= 1'b0;
      RD_W      <= '0;
    end else begin
      RegWriteW   <= RegWriteM & ~(misalign & MemReadM);
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= load_data;
    end
  end

endmodule

// File: tb/tb_memory_cycle_lsu.sv
// Scoreboard bench: zero-latency and three-cycle-latency instances share stimulus,
// one active at a time while the other is held in reset.
module tb_memory_cycle_lsu;
  import riscv_mem_pkg::*;

  typedef struct {
    int          id;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  rsrc;
    logic [31:0] pc4;
    logic [31:0] alu;
    logic [31:0] rdata;
    bit          chk;
    int          stalls;
  } exp_t;

  logic clk = 1'b0;
  logic rst0, rst3, sel;
  logic RegWriteM, MemWriteM, MemReadM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

  logic w0_stall, w0_mis, w0_rw, w3_stall, w3_mis, w3_rw;
  logic [1:0]  w0_rsrc, w3_rsrc;
  logic [4:0]  w0_rd, w3_rd;
  logic [31:0] w0_pc4, w0_alu, w0_rdata, w3_pc4, w3_alu, w3_rdata;

  logic o_stall, o_mis, o_rw;
  logic [1:0]  o_rsrc;
  logic [4:0]  o_rd;
  logic [31:0] o_pc4, o_alu, o_rdata;

  int   total = 0;
  int   bad   = 0;
  int   nid   = 0;
  bit   issued = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  memory_cycle_lsu #(.XLEN(32), .DMEM_DEPTH(1024), .MEM_LATENCY(0)) u0 (
    .clk(clk), .rst(rst0), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
    .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM), .StallM(w0_stall), .MisalignM(w0_mis),
    .RegWriteW(w0_rw), .ResultSrcW(w0_rsrc), .RD_W(w0_rd), .PCPlus4W(w0_pc4),
    .ALU_ResultW(w0_alu), .ReadDataW(w0_rdata)
  );

  memory_cycle_lsu #(.XLEN(32), .DMEM_DEPTH(1024), .MEM_LATENCY(3)) u3 (
    .clk(clk), .rst(rst3), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
    .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM), .StallM(w3_stall), .MisalignM(w3_mis),
    .RegWriteW(w3_rw), .ResultSrcW(w3_rsrc), .RD_W(w3_rd), .PCPlus4W(w3_pc4),
    .ALU_ResultW(w3_alu), .ReadDataW(w3_rdata)
  );

  assign o_stall = sel ? w3_stall : w0_stall;
  assign o_mis   = sel ? w3_mis   : w0_mis;
  assign o_rw    = sel ? w3_rw    : w0_rw;
  assign o_rsrc  = sel ? w3_rsrc  : w0_rsrc;
  assign o_rd    = sel ? w3_rd    : w0_rd;
  assign o_pc4   = sel ? w3_pc4   : w0_pc4;
  assign o_alu   = sel ? w3_alu   : w0_alu;
  assign o_rdata = sel ? w3_rdata : w0_rdata;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endfunction

  task automatic drive_idle();
    RegWriteM = 1'b0; MemWriteM = 1'b0; MemReadM = 1'b0; ResultSrcM = '0; Funct3M = '0;
    RD_M = '0; PCPlus4M = '0; WriteDataM = '0; ALU_ResultM = '0;
  endtask

  task automatic chk_outs_zero(input string pfx);
    check({pfx, " ctl"},   32'({o_rw, o_rsrc, o_rd}), 32'h0);
    check({pfx, " pc4"},   o_pc4,   32'h0);
    check({pfx, " alu"},   o_alu,   32'h0);
    check({pfx, " rdata"}, o_rdata, 32'h0);
    check({pfx, " stall"}, 32'(o_stall), 32'h0);
  endtask

  // Present one instruction, hold it through any stall, and queue its W-stage image.
  task automatic issue(input string nm, input logic rw, input logic wr, input logic rdq,
                       input logic [1:0] rsrc, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] pc4, input logic [31:0] wd, input logic [31:0] addr,
                       input logic exp_rw, input logic exp_mis, input bit chk,
                       input logic [31:0] exp_rd, input int stalls);
    exp_t e;
    int   n;
    RegWriteM = rw; MemWriteM = wr; MemReadM = rdq; ResultSrcM = rsrc; Funct3M = f3;
    RD_M = rd; PCPlus4M = pc4; WriteDataM = wd; ALU_ResultM = addr;
    e.id = nid; e.rw = exp_rw; e.rd = rd; e.rsrc = rsrc; e.pc4 = pc4; e.alu = addr;
    e.rdata = exp_rd; e.chk = chk; e.stalls = stalls;
    exp_q.push_back(e);
    nid++;
    issued = 1'b1;
    @(negedge clk);
    check($sformatf("%s misalign", nm), 32'(o_mis), 32'(exp_mis));
    n = 0;
    while (o_stall && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL %s stall bound: still stalled after %0d cycles, required release", nm, n);
    end
    @(posedge clk); #1;
    issued = 1'b0;
  endtask

  initial begin : monitor
    bit   p_iss;
    bit   p_stall;
    int   run;
    exp_t e;
    p_iss = 1'b0; p_stall = 1'b0; run = 0;
    forever begin
      @(negedge clk);
      if (p_iss && p_stall) begin
        run++;
        check($sformatf("bubble%0d", run), 32'({o_rw, o_rd}), 32'h0);
      end else if (p_iss) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL capture: got an output with an empty queue, required none");
        end else begin
          e = exp_q.pop_front();
          check($sformatf("item%0d rw", e.id),     32'(o_rw),   32'(e.rw));
          check($sformatf("item%0d rd", e.id),     32'(o_rd),   32'(e.rd));
          check($sformatf("item%0d rsrc", e.id),   32'(o_rsrc), 32'(e.rsrc));
          check($sformatf("item%0d pc4", e.id),    o_pc4,       e.pc4);
          check($sformatf("item%0d alu", e.id),    o_alu,       e.alu);
          check($sformatf("item%0d stalls", e.id), run,         e.stalls);
          if (e.chk) check($sformatf("item%0d rdata", e.id), o_rdata, e.rdata);
        end
        run = 0;
      end
      p_iss   = issued;
      p_stall = o_stall;
    end
  end

  initial begin : stimulus
    int n;
    rst0 = 1'b0; rst3 = 1'b0; sel = 1'b0;
    drive_idle();
    #12;
    chk_outs_zero("reset u0");
    sel = 1'b1; #1;
    chk_outs_zero("reset u3");
    sel = 1'b0;
    @(posedge clk); #1;
    rst0 = 1'b1;

    //     name      rw wr rd rsrc     f3     rd  pc4        wdata        addr        erw mis chk erdata        stalls
    issue("sw10",    0, 1, 0, RES_ALU, F3_W,  0,  32'h104, 32'hDEADBEEF, 32'h10,   0, 0, 0, 32'h0,        0);
    issue("lw10",    1, 0, 1, RES_MEM, F3_W,  1,  32'h108, 32'h0,        32'h10,   1, 0, 1, 32'hDEADBEEF, 0);
    issue("sw20",    0, 1, 0, RES_ALU, F3_W,  0,  32'h10C, 32'h11223344, 32'h20,   0, 0, 0, 32'h0,        0);
    issue("sb21",    0, 1, 0, RES_ALU, F3_B,  0,  32'h110, 32'hFFFFFF80, 32'h21,   0, 0, 0, 32'h0,        0);
    issue("lb21",    1, 0, 1, RES_MEM, F3_B,  2,  32'h114, 32'h0,        32'h21,   1, 0, 1, 32'hFFFFFF80, 0);
    issue("lbu21",   1, 0, 1, RES_MEM, F3_BU, 3,  32'h118, 32'h0,        32'h21,   1, 0, 1, 32'h00000080, 0);
    issue("lw20",    1, 0, 1, RES_MEM, F3_W,  4,  32'h11C, 32'h0,        32'h20,   1, 0, 1, 32'h11228044, 0);
    issue("lh22",    1, 0, 1, RES_MEM, F3_H,  6,  32'h120, 32'h0,        32'h22,   1, 0, 1, 32'h00001122, 0);
    issue("lh10",    1, 0, 1, RES_MEM, F3_H,  7,  32'h124, 32'h0,        32'h10,   1, 0, 1, 32'hFFFFBEEF, 0);
    issue("lhu12",   1, 0, 1, RES_MEM, F3_HU, 8,  32'h128, 32'h0,        32'h12,   1, 0, 1, 32'h0000DEAD, 0);
    issue("lb13",    1, 0, 1, RES_MEM, F3_B,  9,  32'h12C, 32'h0,        32'h13,   1, 0, 1, 32'hFFFFFFDE, 0);
    issue("sh13",    0, 1, 0, RES_ALU, F3_H,  0,  32'h130, 32'h0000AAAA, 32'h13,   0, 1, 0, 32'h0,        0);
    issue("lw10b",   1, 0, 1, RES_MEM, F3_W,  10, 32'h134, 32'h0,        32'h10,   1, 0, 1, 32'hDEADBEEF, 0);
    issue("lw12",    1, 0, 1, RES_MEM, F3_W,  11, 32'h138, 32'h0,        32'h12,   0, 1, 0, 32'h0,        0);
    issue("sw1004",  0, 1, 0, RES_ALU, F3_W,  0,  32'h13C, 32'h0A0B0C0D, 32'h1004, 0, 0, 0, 32'h0,        0);
    issue("lw04",    1, 0, 1, RES_MEM, F3_W,  12, 32'h140, 32'h0,        32'h4,    1, 0, 1, 32'h0A0B0C0D, 0);
    issue("alu66",   1, 0, 0, RES_ALU, F3_W,  5,  32'h144, 32'h0,        32'h66,   1, 0, 0, 32'h0,        0);
    issue("jalpc4",  1, 0, 0, RES_PC4, F3_B,  1,  32'h300, 32'h0,        32'h1234, 1, 0, 0, 32'h0,        0);

    @(posedge clk); #1;
    drive_idle();
    rst0 = 1'b0; sel = 1'b1; rst3 = 1'b1;

    issue("sw00",    0, 1, 0, RES_ALU, F3_W,  0,  32'h400, 32'h0BADF00D, 32'h0,    0, 0, 0, 32'h0,        3);
    issue("lw00",    1, 0, 1, RES_MEM, F3_W,  7,  32'h404, 32'h0,        32'h0,    1, 0, 1, 32'h0BADF00D, 3);
    issue("alu3",    1, 0, 0, RES_ALU, F3_B,  5,  32'h408, 32'h0,        32'h66,   1, 0, 0, 32'h0,        0);
    issue("sw40",    0, 1, 0, RES_ALU, F3_W,  0,  32'h40C, 32'hCAFEF00D, 32'h40,   0, 0, 0, 32'h0,        3);

    // Abandoned store: reset lands in the second wait cycle, so nothing is queued for it.
    RegWriteM = 1'b0; MemWriteM = 1'b1; MemReadM = 1'b0; ResultSrcM = RES_ALU; Funct3M = F3_W;
    RD_M = 5'd0; PCPlus4M = 32'h410; WriteDataM = 32'h00001234; ALU_ResultM = 32'h40;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort pre stall", 32'(o_stall), 32'h1);
    rst3 = 1'b0; #1;
    chk_outs_zero("abort reset");
    drive_idle();
    @(posedge clk); #1;
    rst3 = 1'b1; #1;
    check("abort release stall", 32'(o_stall), 32'h0);
    @(posedge clk); #1;

    issue("lw40",    1, 0, 1, RES_MEM, F3_W,  9,  32'h414, 32'h0,        32'h40,   1, 0, 1, 32'hCAFEF00D, 3);
    issue("lw02mis", 1, 0, 1, RES_MEM, F3_W,  3,  32'h418, 32'h0,        32'h2,    0, 1, 0, 32'h0,        0);
    drive_idle();

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: %0d items left in queue, required 0", exp_q.size());
    end
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
